// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory BIST slice.
//   - state_t      : march controller states (IDLE, WR0, RD0, WR1, RD1, DONE)
//   - DEF_ADDR_W   : default memory address width (32K words)
//   - DEF_DATA_W   : default memory data width
//   - PAT_W        : working width of the pattern helper, wide enough for any
//                    sensible ADDR_W/DATA_W so callers just truncate the result
//   - pattern()    : P(x) = zero_extend(x) XOR seed
package mem_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 16;
  localparam int PAT_W      = 64;

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    RD0,
    WR1,
    RD1,
    DONE
  } state_t;

  // The pattern is computed at full helper width; callers zero-extend their
  // address and seed into it and keep only the low DATA_W bits.
  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] x,
                                               input logic [PAT_W-1:0] seed);
    return x ^ seed;
  endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: expected memory word for a given address and march phase.
// Purely combinational.
//   addr  (in,  ADDR_W) : word address
//   phase (in,  state_t): current or upcoming march phase
//   data  (out, DATA_W) : P(addr) in the true phases, ~P(addr) in WR1/RD1
module bist_pattern_gen
  import mem_pkg::*;
#(
  parameter int          ADDR_W = DEF_ADDR_W,
  parameter int          DATA_W = DEF_DATA_W,
  parameter logic [15:0] SEED   = 16'hA5A5
) (
  input  logic [ADDR_W-1:0] addr,
  input  state_t            phase,
  output logic [DATA_W-1:0] data
);

  // The second half of the march works on the inverted pattern so every bit
  // of every word is exercised at both polarities.
  always_comb begin
    data = DATA_W'(pattern(PAT_W'(addr), PAT_W'(SEED)));
    if (phase == WR1 || phase == RD1) begin
      data = ~data;
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: four-phase march BIST for a single-port memory with an
// asynchronous read port.
//   clk       (in)         system clock, rising edge
//   rst_n     (in)         synchronous active-low reset
//   start     (in)         begin a test, honoured only in IDLE
//   abort     (in)         abandon the running test, return to IDLE
//   a         (out ADDR_W) memory address (registered)
//   d         (out DATA_W) memory write data (registered)
//   we        (out)        memory write enable (registered)
//   spo       (in  DATA_W) memory read data, combinational from a
//   busy      (out)        a march phase is active
//   done      (out)        one-cycle pulse on normal completion
//   pass      (out)        last test finished with zero errors
//   err_cnt   (out 16)     saturating mismatch count
//   fail_addr (out ADDR_W) address of the first mismatch
//   fail_data (out DATA_W) spo captured at the first mismatch
module mem_bist_ctrl
  import mem_pkg::*;
#(
  parameter int          ADDR_W = DEF_ADDR_W,
  parameter int          DATA_W = DEF_DATA_W,
  parameter logic [15:0] SEED   = 16'hA5A5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] d,
  output logic              we,
  input  logic [DATA_W-1:0] spo,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] a_next, fail_addr_next;
  logic [DATA_W-1:0] d_next, exp_next, fail_data_next;
  logic              we_next, pass_next, last_addr, mismatch;
  logic [15:0]       err_next;

  // The pattern is generated for the address and phase of the coming cycle so
  // that d can be registered alongside a. During read phases d carries the
  // expected word, which is what the comparator checks spo against.
  bist_pattern_gen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .SEED  (SEED)
  ) u_pattern (
    .addr (a_next),
    .phase(state_next),
    .data (exp_next)
  );

  // Status outputs decode straight from the state register.
  always_comb begin
    busy = state inside {WR0, RD0, WR1, RD1};
    done = (state == DONE);
  end

  // Next-state, address sequencing and error bookkeeping. A phase ends after
  // the cycle at the last address; the address wraps naturally to zero.
  // Abort overrides everything except reset and leaves the error record alone.
  always_comb begin
    state_next     = state;
    a_next         = a;
    pass_next      = pass;
    err_next       = err_cnt;
    fail_addr_next = fail_addr;
    fail_data_next = fail_data;
    last_addr      = (a == LAST_ADDR);
    mismatch       = (spo != d);

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next     = WR0;
          a_next         = '0;
          pass_next      = 1'b0;
          err_next       = '0;
          fail_addr_next = '0;
          fail_data_next = '0;
        end
      end
      WR0: begin
        a_next = a + 1'b1;
        if (last_addr) state_next = RD0;
      end
      WR1: begin
        a_next = a + 1'b1;
        if (last_addr) state_next = RD1;
      end
      RD0, RD1: begin
        a_next = a + 1'b1;
        if (mismatch) begin
          if (err_cnt != 16'hFFFF) err_next = err_cnt + 16'd1;
          if (err_cnt == 16'd0) begin
            fail_addr_next = a;
            fail_data_next = spo;
          end
        end
        if (last_addr) begin
          if (state == RD0) begin
            state_next = WR1;
          end else begin
            state_next = DONE;
            pass_next  = (err_next == 16'd0);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        a_next     = '0;
      end
      default: begin
        state_next = IDLE;
        a_next     = '0;
      end
    endcase

    if (abort && state != IDLE) begin
      state_next     = IDLE;
      a_next         = '0;
      pass_next      = 1'b0;
      err_next       = err_cnt;
      fail_addr_next = fail_addr;
      fail_data_next = fail_data;
    end

    we_next = (state_next == WR0) || (state_next == WR1);
    d_next  = (state_next inside {WR0, RD0, WR1, RD1}) ? exp_next : '0;
  end

  // State and all registered outputs; reset returns every output to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= '0;
      d         <= '0;
      we        <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state     <= state_next;
      a         <= a_next;
      d         <= d_next;
      we        <= we_next;
      pass      <= pass_next;
      err_cnt   <= err_next;
      fail_addr <= fail_addr_next;
      fail_data <= fail_data_next;
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb_mem_bist_ctrl: directed bench for mem_bist_ctrl with a 16-word memory
// model that can inject stuck-at faults on its read port.
module tb_mem_bist_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [AW-1:0] a, fail_addr;
  logic [DW-1:0] d, spo, fail_data;
  logic          we, busy, done, pass;
  logic [15:0]   err_cnt;

  int assertCount = 0;
  int failCount   = 0;
  int faultMode   = 0;
  int busyCycles;
  bit gotDone;

  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  mem_bist_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .SEED  (16'hA5A5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .a        (a),
    .d        (d),
    .we       (we),
    .spo      (spo),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_addr(fail_addr),
    .fail_data(fail_data)
  );

  // Memory model: synchronous write, asynchronous read with optional faults.
  // Mode 1: word 5 bit0 stuck-at-0. Mode 2: words 2 and 9 bit15 stuck-at-1.
  always @(posedge clk) begin
    if (we) mem[a] <= d;
  end

  always_comb begin
    spo = mem[a];
    if (faultMode == 1 && a == 4'd5) spo[0] = 1'b0;
    if (faultMode == 2 && (a == 4'd2 || a == 4'd9)) spo[15] = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulse (or hold) start and follow the march to its done pulse, checking
  // the address sequence, write enable and write data against P(x)=x^A5A5.
  task automatic applyStimulus(input bit holdStart, output int nBusy,
                               output bit seenDone);
    int            phase, addr;
    logic [DW-1:0] pat;
    start = 1'b1;
    tick();
    if (!holdStart) start = 1'b0;
    nBusy    = 0;
    seenDone = 1'b0;
    for (int n = 0; n < 4 * DEPTH + 8 && !seenDone; n++) begin
      if (done) begin
        seenDone = 1'b1;
        checkOutput("busy_at_done", 32'(busy), 0);
      end else begin
        if (busy) begin
          phase = nBusy / DEPTH;
          addr  = nBusy % DEPTH;
          checkOutput("addr_seq", 32'(a), 32'(addr));
          checkOutput("we_phase", 32'(we), (phase == 0 || phase == 2) ? 1 : 0);
          if (phase == 0 || phase == 2) begin
            pat = 16'(addr) ^ 16'hA5A5;
            if (phase == 2) pat = ~pat;
            checkOutput("wr_data", 32'(d), 32'(pat));
          end
          nBusy++;
        end
        tick();
      end
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(seenDone), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_we", 32'(we), 0);
    checkOutput("rst_a", 32'(a), 0);
    checkOutput("rst_pass", 32'(pass), 0);
    checkOutput("rst_err", 32'(err_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Fault-free march.
    $display("[TB] fault-free run");
    applyStimulus(1'b0, busyCycles, gotDone);
    checkOutput("ff_busy_cycles", 32'(busyCycles), 64);
    checkOutput("ff_pass", 32'(pass), 1);
    checkOutput("ff_err", 32'(err_cnt), 0);
    tick();
    checkOutput("ff_done_pulse_ends", 32'(done), 0);
    checkOutput("ff_idle", 32'(busy), 0);

    // Word 5 bit0 stuck-at-0: only the inverse read (5A5F) sees it.
    $display("[TB] stuck-at-0 run");
    faultMode = 1;
    applyStimulus(1'b0, busyCycles, gotDone);
    checkOutput("sa0_err", 32'(err_cnt), 1);
    checkOutput("sa0_fail_addr", 32'(fail_addr), 5);
    checkOutput("sa0_fail_data", 32'(fail_data), 32'h5A5E);
    checkOutput("sa0_pass", 32'(pass), 0);
    tick();

    // Words 2 and 9 bit15 stuck-at-1: P() already has bit15 set, so both
    // fail in the inverse read; the first failure (2, DA58) is kept.
    $display("[TB] stuck-at-1 run");
    faultMode = 2;
    applyStimulus(1'b0, busyCycles, gotDone);
    checkOutput("sa1_err", 32'(err_cnt), 2);
    checkOutput("sa1_fail_addr", 32'(fail_addr), 2);
    checkOutput("sa1_fail_data", 32'(fail_data), 32'hDA58);
    checkOutput("sa1_pass", 32'(pass), 0);
    faultMode = 0;
    tick();

    // Abort and start together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort_start_idle", 32'(busy), 0);
    tick();

    // Abort during RD0 at address 7.
    $display("[TB] abort run");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (23) tick();
    checkOutput("pre_abort_a", 32'(a), 7);
    checkOutput("pre_abort_busy", 32'(busy), 1);
    checkOutput("pre_abort_we", 32'(we), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_we", 32'(we), 0);
    checkOutput("abort_a", 32'(a), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_pass", 32'(pass), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("abort_no_done", 32'(done), 0);
    end
    applyStimulus(1'b0, busyCycles, gotDone);
    checkOutput("post_abort_cycles", 32'(busyCycles), 64);
    checkOutput("post_abort_pass", 32'(pass), 1);
    tick();

    // Start held high for the whole test: exactly one march.
    $display("[TB] held-start run");
    applyStimulus(1'b1, busyCycles, gotDone);
    checkOutput("hold_cycles", 32'(busyCycles), 64);
    checkOutput("hold_pass", 32'(pass), 1);
    tick();
    tick();
    checkOutput("hold_single_run", 32'(busy), 0);

    // Reset in the middle of WR1 (address 5).
    $display("[TB] mid-test reset");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (37) tick();
    checkOutput("pre_rst_we", 32'(we), 1);
    checkOutput("pre_rst_a", 32'(a), 5);
    checkOutput("pre_rst_d", 32'(d), 32'h5A5F);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("mrst_we", 32'(we), 0);
    checkOutput("mrst_busy", 32'(busy), 0);
    checkOutput("mrst_done", 32'(done), 0);
    checkOutput("mrst_a", 32'(a), 0);
    checkOutput("mrst_d", 32'(d), 0);
    checkOutput("mrst_pass", 32'(pass), 0);
    checkOutput("mrst_err", 32'(err_cnt), 0);
    checkOutput("mrst_fail_addr", 32'(fail_addr), 0);
    checkOutput("mrst_fail_data", 32'(fail_data), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
